layer_result_pingpong_buf: RTL and testbench
============================================

// Module: layer_result_pingpong_buf
// PURPOSE
//  Parametrised double-buffered (ping-pong) store for one layer's output feature map.
//  Producer layer writes pixel results by (row,col) into one bank while the consumer layer reads the other.
//  Sits between conv layer N's save path and layer N+1's fetch path.
//  Adds over the single-bank result memory:
//  - generic row*MAP_W+col addressing
//  - bank-ownership handshake
//  - registered read with valid
//  - address-range checking
// PARAMETERS
//  DATA_W  128  width of one stored pixel result (all channels packed)
//  MAP_W   12   feature-map width in pixels
//  MAP_H   12   feature-map height in pixels
//  DEPTH   MAP_W*MAP_H (derived, localparam)  entries per bank
//  ADDR_W  $clog2(DEPTH) (derived, localparam)  bank address width
// PORTS
//  clk              in   1       clock; all state on posedge
//  rst              in   1       asynchronous reset, active-low
//  save_enable      in   1       write pixel this cycle
//  save_row_addr    in   16      write row
//  save_col_addr    in   16      write col
//  store_data_in    in   DATA_W  write data
//  save_done        in   1       pulse: producer finished current bank
//  save_ready       out  1       a bank is owned by producer (FREE)
//  read_signal      in   1       read pixel this cycle
//  read_row_addr    in   16      read row
//  read_col_addr    in   16      read col
//  read_done        in   1       pulse: consumer finished current bank
//  read_ready       out  1       a FULL bank is owned by consumer
//  result_output    out  DATA_W  read data, 1 cycle after read_signal
//  result_valid     out  1       result_output is valid
//  addr_err         out  1       sticky: out-of-range or unowned access seen
// BEHAVIOUR
//  Reset (rst=0, async):
//  - bank_state[0..1]=FREE; wr_ptr=0; rd_ptr=0
//  - result_output=0; result_valid=0; addr_err=0
//  - SRAM contents undefined
//  Bank handshake, per-bank state in {FREE, FULL}:
//  - save_ready = (bank_state[wr_ptr]==FREE); read_ready = (bank_state[rd_ptr]==FULL).
//  - save_done && save_ready: bank_state[wr_ptr]<=FULL; wr_ptr toggles.
//  - read_done && read_ready: bank_state[rd_ptr]<=FREE; rd_ptr toggles.
//  - save_done when !save_ready, or read_done when !read_ready: ignored, no flag.
//  - One bank cannot be FREE and FULL together, so both done pulses in one cycle always act on different banks; both take effect.
//  Addressing: addr = row*MAP_W + col, truncated to ADDR_W.
//  - Multiply is generic, not hard-coded shifts.
//  - In range iff row<MAP_H and col<MAP_W; no wrap.
//  Write:
//  - Accepted iff save_enable && save_ready && in range; lands in bank wr_ptr at the same posedge.
//  - save_enable together with save_done: the write lands in the old bank, before the toggle.
//  - Rejected write: SRAM unchanged; addr_err<=1.
//  Read:
//  - Accepted iff read_signal && read_ready && in range; bank rd_ptr, latency 1.
//  - Next cycle: result_valid=1, result_output=data.
//  - Otherwise next cycle: result_valid=0, result_output=0.
//  - Unowned or out-of-range read_signal: addr_err<=1.
//  - read_signal together with read_done: served from the old bank.
//  Producer and consumer always own different banks, so there are no read/write collisions.
//  addr_err is cleared only by reset.
//  Reset mid-operation: every bank is FREE, so data in flight is discarded and result_valid drops asynchronously.
// STRUCTURE
//  Package layer_buf_pkg:
//  - typedef enum logic {BANK_FREE, BANK_FULL} bank_state_t
//  - function pix_addr(row, col, map_w)
//  - defaults for DATA_W, MAP_W and MAP_H
//  Sub-module layer_result_bank, instantiated twice:
//  - 1W1R synchronous SRAM model, DEPTH x DATA_W, registered read
//  - swappable with the foundry SRAM wrapper
//  Top holds: ptrs, bank states, address calc and range check, output mux/valid register.
// TESTING (DATA_W=128, MAP_W=12, MAP_H=12)
//  1. Reset, write (r,c)->data=r*12+c for all 144 px, save_done; read (11,11) -> next cycle valid=1, data=143; read (0,0) -> 0.
//  2. Bank 0 FULL, write bank 1 with data+1000 while reading bank 0 -> reads return bank-0 values; no cross-bank corruption.
//  3. save_done and read_done in the same cycle with bank0 FULL, bank1 filled:
//     -> bank0 FREE, bank1 FULL, wr_ptr=0, rd_ptr=1, save_ready=1, read_ready=1.
//  4. Write (12,0) or read (0,12) -> no SRAM change, result_valid=0, result_output=0, addr_err=1 and sticky.
//  5. Both banks FULL, save_enable -> ignored, addr_err=1; read_signal with no FULL bank -> result_valid=0.
//  6. Assert rst=0 mid-read -> result_valid=0 immediately, save_ready=1, read_ready=0, addr_err=0.

Source files
------------

// File: rtl/layer_result_pingpong_buf_pkg.sv
// Shared types, defaults and pixel addressing for the ping-pong layer result buffer.
package layer_buf_pkg;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_t;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_MAP_W  = 12;
    localparam int DEF_MAP_H  = 12;
    localparam int COORD_W    = 16;

    // Generic row-major address; caller truncates to its bank address width.
    function automatic logic [31:0] pix_addr(input logic [COORD_W-1:0] row,
                                             input logic [COORD_W-1:0] col,
                                             input logic [31:0]        map_w);
        return 32'(row) * map_w + 32'(col);
    endfunction

endpackage

// File: rtl/layer_result_pingpong_buf_if.sv
// Producer-save and consumer-read signal bundle of the ping-pong layer result buffer.
interface layer_result_pingpong_buf_if
    import layer_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic               save_enable;
    logic [COORD_W-1:0] save_row_addr;
    logic [COORD_W-1:0] save_col_addr;
    logic [DATA_W-1:0]  store_data_in;
    logic               save_done;
    logic               save_ready;
    logic               read_signal;
    logic [COORD_W-1:0] read_row_addr;
    logic [COORD_W-1:0] read_col_addr;
    logic               read_done;
    logic               read_ready;
    logic [DATA_W-1:0]  result_output;
    logic               result_valid;
    logic               addr_err;

    modport master (
        output save_enable, save_row_addr, save_col_addr, store_data_in, save_done,
        output read_signal, read_row_addr, read_col_addr, read_done,
        input  save_ready, read_ready, result_output, result_valid, addr_err
    );

    modport slave (
        input  save_enable, save_row_addr, save_col_addr, store_data_in, save_done,
        input  read_signal, read_row_addr, read_col_addr, read_done,
        output save_ready, read_ready, result_output, result_valid, addr_err
    );
endinterface

// File: rtl/layer_result_pingpong_buf_bank.sv
// One bank of the ping-pong buffer: 1W1R synchronous SRAM model with registered read.
// Port list mirrors the foundry SRAM wrapper so the two can be swapped.
module layer_result_bank #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 144,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/layer_result_pingpong_buf.sv
// Double-buffered feature-map store: producer fills one bank while the consumer drains the other.
module layer_result_pingpong_buf
    import layer_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAP_W  = DEF_MAP_W,
    parameter int MAP_H  = DEF_MAP_H
) (
    input  logic                         clk,
    input  logic                         rst,
    layer_result_pingpong_buf_if.slave   bus
);
    localparam int DEPTH  = MAP_W * MAP_H;
    localparam int ADDR_W = $clog2(DEPTH);

    bank_state_t       bank_state [2];
    logic              wr_ptr;
    logic              rd_ptr;

    logic              save_in_range_p0;
    logic              read_in_range_p0;
    logic [ADDR_W-1:0] wr_addr_p0;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic              wr_ok_p0;
    logic              rd_ok_p0;
    logic              save_take_p0;
    logic              read_take_p0;
    logic              err_p0;
    logic [1:0]        bank_we_p0;
    logic [1:0]        bank_re_p0;

    logic [DATA_W-1:0] bank_q [2];
    logic              vld_p1;
    logic              rd_sel_p1;
    logic              addr_err_q;

    // ---- stage p0: handshake, address calc, range check ----
    assign bus.save_ready = (bank_state[wr_ptr] == BANK_FREE);
    assign bus.read_ready = (bank_state[rd_ptr] == BANK_FULL);

    assign save_in_range_p0 = (32'(bus.save_row_addr) < 32'(MAP_H)) &&
                              (32'(bus.save_col_addr) < 32'(MAP_W));
    assign read_in_range_p0 = (32'(bus.read_row_addr) < 32'(MAP_H)) &&
                              (32'(bus.read_col_addr) < 32'(MAP_W));

    assign wr_addr_p0 = ADDR_W'(pix_addr(bus.save_row_addr, bus.save_col_addr, 32'(MAP_W)));
    assign rd_addr_p0 = ADDR_W'(pix_addr(bus.read_row_addr, bus.read_col_addr, 32'(MAP_W)));

    assign wr_ok_p0     = bus.save_enable && bus.save_ready && save_in_range_p0;
    assign rd_ok_p0     = bus.read_signal && bus.read_ready && read_in_range_p0;
    assign save_take_p0 = bus.save_done && bus.save_ready;
    assign read_take_p0 = bus.read_done && bus.read_ready;
    assign err_p0       = (bus.save_enable && !wr_ok_p0) || (bus.read_signal && !rd_ok_p0);

    // Accesses use the pre-toggle pointers, so a done pulse still lets this cycle's access hit the old bank.
    assign bank_we_p0 = {wr_ok_p0 &&  wr_ptr, wr_ok_p0 && !wr_ptr};
    assign bank_re_p0 = {rd_ok_p0 &&  rd_ptr, rd_ok_p0 && !rd_ptr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                bank_state[i] <= BANK_FREE;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            // Producer and consumer never own the same bank, so both updates can land together.
            for (int i = 0; i < 2; i++) begin
                if (save_take_p0 && (wr_ptr == 1'(i))) begin
                    bank_state[i] <= BANK_FULL;
                end else if (read_take_p0 && (rd_ptr == 1'(i))) begin
                    bank_state[i] <= BANK_FREE;
                end
            end
            if (save_take_p0) begin
                wr_ptr <= !wr_ptr;
            end
            if (read_take_p0) begin
                rd_ptr <= !rd_ptr;
            end
            if (err_p0) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        layer_result_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (bank_we_p0[b]),
            .wr_addr (wr_addr_p0),
            .wr_data (bus.store_data_in),
            .rd_en   (bank_re_p0[b]),
            .rd_addr (rd_addr_p0),
            .rd_data (bank_q[b])
        );
    end

    // ---- stage p1: read valid and bank select, aligned with SRAM output ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1    <= 1'b0;
            rd_sel_p1 <= 1'b0;
        end else begin
            vld_p1    <= rd_ok_p0;
            rd_sel_p1 <= rd_ptr;
        end
    end

    // Gating by the async-reset valid forces zero output immediately on reset and on idle cycles.
    assign bus.result_valid  = vld_p1;
    assign bus.result_output = vld_p1 ? bank_q[rd_sel_p1] : '0;
    assign bus.addr_err      = addr_err_q;

endmodule

// File: tb/tb_layer_result_pingpong_buf.sv
// Self-checking bench for layer_result_pingpong_buf: directed table plus randomized run against a model.
module tb_layer_result_pingpong_buf;
    localparam int DW = 128;
    localparam int MW = 12;
    localparam int MH = 12;
    localparam int NPIX = MW * MH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer_result_pingpong_buf_if #(.DATA_W(DW)) bus ();

    layer_result_pingpong_buf #(
        .DATA_W (DW),
        .MAP_W  (MW),
        .MAP_H  (MH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          se;
        logic [15:0]   sr;
        logic [15:0]   sc;
        logic [DW-1:0] sd;
        logic          sdone;
        logic          rs;
        logic [15:0]   rr;
        logic [15:0]   rc;
        logic          rdone;
        logic          e_vld;
        logic [DW-1:0] e_out;
        logic          e_sready;
        logic          e_rready;
        logic          e_err;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: bank ownership derived from counts of completed saves and reads.
    logic [DW-1:0] mmem  [2][NPIX];
    bit            known [2][NPIX];
    int            ns;
    int            nr;
    bit            merr;

    function automatic vec_t mk(logic se, int sr, int sc, logic [DW-1:0] sd, logic sdone,
                                logic rs, int rr, int rc, logic rdone,
                                logic ev, logic [DW-1:0] eo, logic esr, logic err_r, logic ee);
        vec_t v;
        v.se = se; v.sr = 16'(sr); v.sc = 16'(sc); v.sd = sd; v.sdone = sdone;
        v.rs = rs; v.rr = 16'(rr); v.rc = 16'(rc); v.rdone = rdone;
        v.e_vld = ev; v.e_out = eo; v.e_sready = esr; v.e_rready = err_r; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.save_enable   = v.se;
        bus.save_row_addr = v.sr;
        bus.save_col_addr = v.sc;
        bus.store_data_in = v.sd;
        bus.save_done     = v.sdone;
        bus.read_signal   = v.rs;
        bus.read_row_addr = v.rr;
        bus.read_col_addr = v.rc;
        bus.read_done     = v.rdone;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".valid"},  DW'(bus.result_valid), DW'(v.e_vld));
        chk({tag, ".output"}, bus.result_output,     v.e_out);
        chk({tag, ".sready"}, DW'(bus.save_ready),   DW'(v.e_sready));
        chk({tag, ".rready"}, DW'(bus.read_ready),   DW'(v.e_rready));
        chk({tag, ".err"},    DW'(bus.addr_err),     DW'(v.e_err));
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v);
        tick();
        chk_all(tag, v);
    endtask

    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, '0, 0, 0, 0, 0, 0, 0, '0, 1, 0, 0);
        drive(idle);
        rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        tick();
        chk_all("reset", idle);
        rst = 1'b1;

        // Fill bank 0 with r*12+c, then hand it over.
        for (int r = 0; r < MH; r++) begin
            for (int c = 0; c < MW; c++) begin
                drive(mk(1, r, c, DW'(r * MW + c), 0, 0, 0, 0, 0, 0, '0, 1, 0, 0));
                tick();
            end
        end
        apply("fill_done", mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0, '0, 1, 1, 0));
        apply("rd_11_11", mk(0, 0, 0, '0, 0, 1, 11, 11, 0, 1, DW'(143), 1, 1, 0));
        apply("rd_0_0",   mk(0, 0, 0, '0, 0, 1, 0, 0, 0, 1, DW'(0), 1, 1, 0));

        tbl.push_back(mk(1, 0, 0, DW'(1000), 0, 1, 5, 5, 0,   1, DW'(65),   1, 1, 0));
        tbl.push_back(mk(1, 11, 11, DW'(1143), 0, 1, 0, 0, 0, 1, DW'(0),    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, '0, 0, 1, 11, 11, 0,        1, DW'(143),  1, 1, 0));
        tbl.push_back(mk(0, 0, 0, '0, 1, 0, 0, 0, 1,          0, '0,        1, 1, 0));
        tbl.push_back(mk(0, 0, 0, '0, 0, 1, 11, 11, 0,        1, DW'(1143), 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, '0, 0, 1, 0, 0, 0,          1, DW'(1000), 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, '0, 0, 1, 0, 12, 0,         0, '0,        1, 1, 1));
        tbl.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0, 0,          0, '0,        1, 1, 1));
        tbl.push_back(mk(1, 12, 0, DW'(7), 0, 0, 0, 0, 0,     0, '0,        1, 1, 1));
        tbl.push_back(mk(1, 0, 0, DW'(5), 1, 0, 0, 0, 0,      0, '0,        0, 1, 1));
        tbl.push_back(mk(1, 1, 1, DW'(9), 0, 0, 0, 0, 0,      0, '0,        0, 1, 1));
        tbl.push_back(mk(0, 0, 0, '0, 0, 1, 0, 0, 1,          1, DW'(1000), 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, '0, 0, 1, 0, 0, 0,          1, DW'(5),    1, 1, 1));
        tbl.push_back(mk(0, 0, 0, '0, 0, 1, 1, 1, 0,          1, DW'(13),   1, 1, 1));
        tbl.push_back(mk(0, 0, 0, '0, 0, 0, 0, 0, 1,          0, '0,        1, 0, 1));
        tbl.push_back(mk(0, 0, 0, '0, 0, 1, 0, 0, 0,          0, '0,        1, 0, 1));
        foreach (tbl[i]) begin
            apply($sformatf("tbl%0d", i), tbl[i]);
        end

        // Make a read valid, then pull reset between edges.
        apply("pre_rst_wr", mk(1, 2, 3, DW'(12'hABC), 1, 0, 0, 0, 0, 0, '0, 1, 1, 1));
        apply("pre_rst_rd", mk(0, 0, 0, '0, 0, 1, 2, 3, 0, 1, DW'(12'hABC), 1, 1, 1));
        drive(idle);
        #2 rst = 1'b0;
        #1;
        chk_all("midread_rst", idle);
        tick();
        rst = 1'b1;

        ns = 0;
        nr = 0;
        merr = 0;
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < NPIX; a++) begin
                known[b][a] = 0;
            end
        end

        for (int k = 0; k < 800; k++) begin
            vec_t v;
            int occ;
            int wb;
            int rb;
            int a;
            bit s_in;
            bit r_in;
            bit dknown;
            v.se    = ($urandom_range(0, 1) == 1);
            v.sr    = 16'($urandom_range(0, 12));
            v.sc    = 16'($urandom_range(0, 12));
            v.sd    = {$urandom, $urandom, $urandom, $urandom};
            v.sdone = ($urandom_range(0, 19) == 0);
            v.rs    = ($urandom_range(0, 1) == 1);
            v.rr    = 16'($urandom_range(0, 12));
            v.rc    = 16'($urandom_range(0, 12));
            v.rdone = ($urandom_range(0, 19) == 0);

            occ    = ns - nr;
            wb     = ns % 2;
            rb     = nr % 2;
            s_in   = (v.sr < MH) && (v.sc < MW);
            r_in   = (v.rr < MH) && (v.rc < MW);
            dknown = 1;
            if (v.rs && occ > 0 && r_in) begin
                a = int'(v.rr) * MW + int'(v.rc);
                v.e_vld = 1;
                v.e_out = mmem[rb][a];
                dknown  = known[rb][a];
            end else begin
                v.e_vld = 0;
                v.e_out = '0;
            end
            if (v.se && occ < 2 && s_in) begin
                a = int'(v.sr) * MW + int'(v.sc);
                mmem[wb][a]  = v.sd;
                known[wb][a] = 1;
            end
            if ((v.se && !(occ < 2 && s_in)) || (v.rs && !(occ > 0 && r_in))) begin
                merr = 1;
            end
            if (v.sdone && occ < 2) ns++;
            if (v.rdone && occ > 0) nr++;
            v.e_sready = ((ns - nr) < 2);
            v.e_rready = ((ns - nr) > 0);
            v.e_err    = merr;

            drive(v);
            tick();
            chk($sformatf("rnd%0d.valid", k), DW'(bus.result_valid), DW'(v.e_vld));
            if (dknown) begin
                chk($sformatf("rnd%0d.output", k), bus.result_output, v.e_out);
            end
            chk($sformatf("rnd%0d.sready", k), DW'(bus.save_ready), DW'(v.e_sready));
            chk($sformatf("rnd%0d.rready", k), DW'(bus.read_ready), DW'(v.e_rready));
            chk($sformatf("rnd%0d.err", k),    DW'(bus.addr_err),   DW'(v.e_err));
        end

        drive(idle);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
